// File: rtl/multi_alu_param.sv
// Parametrised multi-function ALU: debounced load buttons for A, B and op code, registered
// flag generation, and a scanned 8-digit active-low 7-segment display.
module multi_alu_param #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned SCAN_DIV  = 50_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_f,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       view,
  output logic [3:0]       fr,
  output logic             err,
  output logic [7:0]       seg,
  output logic [2:0]       which
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned ScW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Button index: 0 = ld_a, 1 = ld_b, 2 = ld_f.
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q, lvl_q, pulse_q;
  logic [DbW-1:0] db_cnt_q [3];

  assign btn_raw = {ld_f, ld_b, ld_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      pulse_q <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          db_cnt_q[i] <= '0;
          lvl_q[i]    <= sync2_q[i];
          pulse_q[i]  <= sync2_q[i];  // press only; release flips level silently
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
  logic [3:0]       op_q, fr_q, fr_d;
  logic             err_q, err_d, strobe_q;
  logic [WIDTH:0]   add_w, sub_w;
  logic [ShW-1:0]   sh;
  logic             cf, of;

  always_comb begin
    sh    = b_q[ShW-1:0];
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} - {1'b0, b_q};
    f_d   = '0;
    cf    = 1'b0;
    of    = 1'b0;
    err_d = 1'b0;
    case (op_q)
      4'h0: f_d = a_q & b_q;
      4'h1: f_d = a_q | b_q;
      4'h2: f_d = a_q ^ b_q;
      4'h3: f_d = ~(a_q | b_q);
      4'h4: begin
        f_d = add_w[WIDTH-1:0];
        cf  = add_w[WIDTH];
        of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (f_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h5: begin
        f_d = sub_w[WIDTH-1:0];
        cf  = sub_w[WIDTH];  // borrow out equals unsigned A < B
        of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (f_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h6: f_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      4'h7: f_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
      4'h8: f_d = a_q << sh;
      4'h9: f_d = a_q >> sh;
      4'hA: f_d = $unsigned($signed(a_q) >>> sh);
      default: err_d = 1'b1;
    endcase
    fr_d = err_d ? 4'b1000 : {f_d == '0, cf, of, f_d[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      f_q      <= '0;
      fr_q     <= '0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      if (pulse_q[0]) a_q  <= sw;
      if (pulse_q[1]) b_q  <= sw;
      if (pulse_q[2]) op_q <= sw[3:0];
      // One compute after any load, seeing every register loaded in that cycle.
      strobe_q <= |pulse_q;
      if (strobe_q) begin
        f_q   <= f_d;
        fr_q  <= fr_d;
        err_q <= err_d;
      end
    end
  end

  logic [ScW-1:0]   scan_q;
  logic [2:0]       which_q, which_nx;
  logic [7:0]       seg_q;
  logic [WIDTH-1:0] src;
  logic [31:0]      src_ext;
  logic [3:0]       nib;
  logic             blank;

  always_comb begin
    which_nx = which_q + 3'd1;
    unique case (view)
      2'd0:    src = f_q;
      2'd1:    src = a_q;
      2'd2:    src = b_q;
      default: src = '0;
    endcase
    src_ext = 32'(src);
    nib     = src_ext[{which_nx, 2'b00} +: 4];
    blank   = 32'(which_nx) >= (WIDTH / 4);
    if (view == 2'd3) begin
      nib   = which_nx[0] ? op_q : fr_q;
      blank = which_nx > 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q  <= '0;
      which_q <= '0;
      seg_q   <= 8'hFF;
    end else if (scan_q == ScW'(SCAN_DIV - 1)) begin
      scan_q  <= '0;
      which_q <= which_nx;
      seg_q   <= blank ? 8'hFF : hex_glyph(nib);
    end else begin
      scan_q  <= scan_q + ScW'(1);
    end
  end

  assign fr    = fr_q;
  assign err   = err_q;
  assign seg   = seg_q;
  assign which = which_q;

endmodule

// File: tb/tb_multi_alu_param.sv
// Directed bench for multi_alu_param: a 32-bit and a 16-bit build share stimulus; results are
// read back through the scanned display and the flag outputs.
module tb_multi_alu_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_a, ld_b, ld_f;
  logic [31:0] sw;
  logic [1:0]  view;
  logic [3:0]  fr, fr16;
  logic        err, err16;
  logic [7:0]  seg, seg16;
  logic [2:0]  which, which16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  multi_alu_param #(.WIDTH(32), .DB_CYCLES(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f), .sw(sw), .view(view),
    .fr(fr), .err(err), .seg(seg), .which(which)
  );

  multi_alu_param #(.WIDTH(16), .DB_CYCLES(4), .SCAN_DIV(2)) dut16 (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f), .sw(sw[15:0]), .view(view),
    .fr(fr16), .err(err16), .seg(seg16), .which(which16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic logic [63:0] exp_disp(input logic [31:0] v, input int ndig);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = (i < ndig) ? glyph(v[4*i +: 4]) : 8'hFF;
    return r;
  endfunction

  task automatic read_disp(output logic [63:0] s32, output logic [63:0] s16);
    int t;
    int to;
    to  = 0;
    s32 = '0;
    s16 = '0;
    t   = 0;
    while (which != 3'd7 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) to++;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (which != 3'(i) && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) to++;
      s32[8*i +: 8] = seg;
      s16[8*i +: 8] = seg16;
    end
    check("scan_timeout", 64'(to), 64'd0);
  endtask

  task automatic check_disp(input string tag, input logic [1:0] v, input logic [31:0] e32,
                            input int nd32, input bit chk16, input logic [15:0] e16);
    logic [63:0] s32, s16;
    view = v;
    read_disp(s32, s16);
    check(tag, s32, exp_disp(e32, nd32));
    if (chk16) check({tag, "_w16"}, s16, exp_disp({16'd0, e16}, 4));
  endtask

  // btns = {f, b, a}; held long enough to debounce in and out again.
  task automatic press(input logic [2:0] btns, input logic [31:0] val);
    sw = val;
    {ld_f, ld_b, ld_a} = btns;
    repeat (12) @(negedge clk);
    {ld_f, ld_b, ld_a} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ef,
                        input logic [3:0] efr, input logic eerr);
    press(3'b100, {28'd0, op});
    check({tag, "_fr"}, 64'(fr), 64'(efr));
    check({tag, "_err"}, 64'(err), 64'(eerr));
    check_disp({tag, "_F"}, 2'd0, ef, 8, 1'b0, 16'd0);
  endtask

  logic [31:0] logic_f  [5] = '{32'h30300004, 32'hFCFC1234, 32'hCCCC1230, 32'h0303EDCB,
                                32'h0F012340};
  logic [3:0]  logic_op [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8};
  logic [3:0]  logic_fr [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

  initial begin
    int t;
    logic [2:0] w0, prev;
    rst = 1'b1;
    {ld_f, ld_b, ld_a} = 3'b000;
    sw = '0;
    view = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_fr", 64'(fr), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_which", 64'(which), 64'd0);
    check("rst_seg", 64'(seg), 64'hFF);
    rst = 1'b0;

    // Bouncing button never settles long enough to load.
    sw = 32'hDEADBEEF;
    for (int k = 0; k < 10; k++) begin
      ld_a = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    ld_a = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_fr", 64'(fr), 64'd0);
    check_disp("bounce_A", 2'd1, 32'd0, 8, 1'b1, 16'd0);

    press(3'b001, 32'h7FFFFFFF);
    press(3'b010, 32'h00000001);
    run_op("add_ovf", 4'h4, 32'h80000000, 4'b0011, 1'b0);
    check_disp("view3", 2'd3, {24'd0, 4'h4, 4'b0011}, 2, 1'b0, 16'd0);

    press(3'b001, 32'd5);
    press(3'b010, 32'd7);
    run_op("sub", 4'h5, 32'hFFFFFFFE, 4'b0101, 1'b0);
    run_op("slt", 4'h6, 32'd1, 4'b0000, 1'b0);
    run_op("sltu", 4'h7, 32'd1, 4'b0000, 1'b0);

    press(3'b001, 32'h80000000);
    press(3'b010, 32'd4);
    run_op("sra", 4'hA, 32'hF8000000, 4'b0001, 1'b0);
    run_op("srl", 4'h9, 32'h08000000, 4'b0000, 1'b0);
    run_op("undef", 4'hF, 32'd0, 4'b1000, 1'b1);

    press(3'b001, 32'hF0F01234);
    press(3'b010, 32'h3C3C0004);
    for (int k = 0; k < 5; k++) run_op($sformatf("logic%0d", k), logic_op[k], logic_f[k],
                                       logic_fr[k], 1'b0);

    // Simultaneous A and B load: one compute sees both new values.
    press(3'b100, 32'd4);
    press(3'b011, 32'd3);
    check("both_fr", 64'(fr), 64'd0);
    check_disp("both_F", 2'd0, 32'd6, 8, 1'b0, 16'd0);

    press(3'b001, 32'h12345678);
    press(3'b010, 32'd0);
    press(3'b100, 32'd1);
    check_disp("disp_F", 2'd0, 32'h12345678, 8, 1'b1, 16'h5678);

    // Scan stepping: which advances every 2 cycles, wrapping 7 -> 0.
    prev = which;
    t = 0;
    @(negedge clk);
    while (which == prev && t < 10) begin prev = which; @(negedge clk); t++; end
    check("scan_start", 64'(t >= 10), 64'd0);
    w0 = which;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("which%0d", k), 64'(which), 64'(3'(w0 + 3'(k / 2))));
      @(negedge clk);
    end

    // Reset mid-operation clears err and debounce progress of a held button.
    press(3'b100, 32'hB);
    check("pre_rst_err", 64'(err), 64'd1);
    sw = 32'h11;
    ld_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_fr", 64'(fr), 64'd0);
    check("mid_rst_which", 64'(which), 64'd0);
    check("mid_rst_seg", 64'(seg), 64'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_early_load", 64'(fr), 64'd0);
    t = 0;
    while (fr != 4'b1000 && t < 20) begin @(negedge clk); t++; end
    check("rst_reload_fr", 64'(fr), 64'b1000);
    ld_a = 1'b0;
    check_disp("rst_reload_A", 2'd1, 32'h11, 8, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
